// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared widths, entry/commit types and pointer helper for the
//               store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 7
`endif
`ifndef STORE_BUFFER_SIZE
`define STORE_BUFFER_SIZE 16
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package store_buffer_pkg;

  localparam int ADDR_WIDTH        = `ADDR_WIDTH;
  localparam int SIZE_WIDTH        = `SIZE_WIDTH;
  localparam int ROB_ID_WIDTH      = `ROB_ID_WIDTH;
  localparam int STORE_BUFFER_SIZE = `STORE_BUFFER_SIZE;
  localparam int COMMIT_WIDTH      = `COMMIT_WIDTH;

  localparam int BUS_DATA_WIDTH  = 32;
  localparam int REG_DATA_WIDTH  = 32;
  localparam int BUS_BYTES       = BUS_DATA_WIDTH / 8;
  localparam int STBUF_PTR_WIDTH = $clog2(STORE_BUFFER_SIZE);
  localparam int STBUF_CNT_WIDTH = $clog2(STORE_BUFFER_SIZE + 1);

  typedef struct packed {
    logic                                      enable;
    logic                                      flush;
    logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0] committed_rob_id;
    logic [COMMIT_WIDTH-1:0]                   committed_rob_id_valid;
  } commit_feedback_pack_t;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0]   rob_id;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [SIZE_WIDTH-1:0]     size;
    logic [REG_DATA_WIDTH-1:0] data;
    logic                      committed;
  } store_buffer_item_t;

  // Ring arithmetic that stays correct for entry counts that are not powers of two.
  function automatic logic [STBUF_PTR_WIDTH-1:0] ptr_add(input logic [STBUF_PTR_WIDTH-1:0] ptr,
                                                         input int off);
    int sum;
    sum = int'(ptr) + off;
    return STBUF_PTR_WIDTH'(sum % STORE_BUFFER_SIZE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// Module      : store_buffer_if
// Description : Data-bus read and write channels between store buffer and bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_buffer_if;
  import store_buffer_pkg::*;

  logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size;
  logic                      stbuf_bus_read_req;
  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size;
  logic [BUS_DATA_WIDTH-1:0] stbuf_bus_data;
  logic                      stbuf_bus_write_req;
  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_data;
  logic                      bus_stbuf_read_ack;
  logic                      bus_stbuf_write_ack;

  modport master (
    output stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_read_req,
    output stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_data, stbuf_bus_write_req,
    input  bus_stbuf_data, bus_stbuf_read_ack, bus_stbuf_write_ack
  );

  modport slave (
    input  stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_read_req,
    input  stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_data, stbuf_bus_write_req,
    output bus_stbuf_data, bus_stbuf_read_ack, bus_stbuf_write_ack
  );

endinterface

`default_nettype wire

// File: rtl/store_buffer_forward.sv
// ============================================================================
// Module      : store_buffer_forward
// Description : Combinational little-endian byte merge of buffered stores over
//               the latched 4-byte read window (used when STORE_BUFFER_FORWARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer_forward
  import store_buffer_pkg::*;
(
  input  logic [STORE_BUFFER_SIZE-1:0][ADDR_WIDTH-1:0]     i_entry_addr,
  input  logic [STORE_BUFFER_SIZE-1:0][SIZE_WIDTH-1:0]     i_entry_size,
  input  logic [STORE_BUFFER_SIZE-1:0][REG_DATA_WIDTH-1:0] i_entry_data,
  input  logic [STBUF_PTR_WIDTH-1:0]                       i_head,
  input  logic [STBUF_CNT_WIDTH-1:0]                       i_count,
  input  logic [ADDR_WIDTH-1:0]                            i_read_addr,
  input  logic [BUS_DATA_WIDTH-1:0]                        i_bus_data,
  output logic [BUS_DATA_WIDTH-1:0]                        o_feedback
);

  logic [STBUF_PTR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0]      w_byte_addr;
  logic [ADDR_WIDTH-1:0]      w_diff;

  // Walk oldest to youngest so the youngest overlapping store lands last.
  always_comb begin
    o_feedback  = i_bus_data;
    w_idx       = '0;
    w_byte_addr = '0;
    w_diff      = '0;
    for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
      w_idx = ptr_add(i_head, i);
      for (int k = 0; k < BUS_BYTES; k++) begin
        w_byte_addr = i_read_addr + ADDR_WIDTH'(k);
        w_diff      = w_byte_addr - i_entry_addr[w_idx];
        if ((i < int'(i_count)) && (w_diff < ADDR_WIDTH'(i_entry_size[w_idx]))) begin
          o_feedback[8*k +: 8] = i_entry_data[w_idx][8*w_diff[1:0] +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : In-order store buffer with commit, flush, bus drain and load
//               forwarding (forwarding built only with STORE_BUFFER_FORWARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     issue_stbuf_read_addr,
  input  logic [SIZE_WIDTH-1:0]     issue_stbuf_read_size,
  input  logic                      issue_stbuf_rd,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
  output logic                      stbuf_exlsu_bus_ready,
  input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
  input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
  input  logic [REG_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
  input  logic                      exlsu_stbuf_push,
  output logic                      stbuf_exlsu_full,
  output logic                      stbuf_all_empty,
  store_buffer_if.master            bus,
  input  commit_feedback_pack_t     commit_feedback_pack
);

  store_buffer_item_t [STORE_BUFFER_SIZE-1:0] r_items;
  logic [STBUF_PTR_WIDTH-1:0] r_head;
  logic [STBUF_PTR_WIDTH-1:0] r_tail;
  logic [STBUF_CNT_WIDTH-1:0] r_count;

  logic [STORE_BUFFER_SIZE-1:0] w_commit_hit;
  logic [STORE_BUFFER_SIZE-1:0] w_committed_next;
  logic [STBUF_CNT_WIDTH-1:0]   w_keep;
  logic                         w_run;
  logic                         w_flush;
  logic                         w_push;
  logic                         w_pop;

  assign w_flush          = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign stbuf_exlsu_full = (r_count == STBUF_CNT_WIDTH'(STORE_BUFFER_SIZE));
  assign stbuf_all_empty  = (r_count == '0);
  assign w_push           = exlsu_stbuf_push & ~stbuf_exlsu_full & ~w_flush;
  assign w_pop            = bus.stbuf_bus_write_req & bus.bus_stbuf_write_ack;

  assign bus.stbuf_bus_write_req  = ~stbuf_all_empty & r_items[r_head].committed & ~w_flush;
  assign bus.stbuf_bus_write_addr = r_items[r_head].addr;
  assign bus.stbuf_bus_write_size = r_items[r_head].size;
  assign bus.stbuf_bus_data       = r_items[r_head].data;

  always_comb begin
    w_commit_hit     = '0;
    w_committed_next = '0;
    for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_feedback_pack.enable && commit_feedback_pack.committed_rob_id_valid[j] &&
            (commit_feedback_pack.committed_rob_id[j] == r_items[i].rob_id)) begin
          w_commit_hit[i] = 1'b1;
        end
      end
      w_committed_next[i] = r_items[i].committed | w_commit_hit[i];
    end
  end

  // Flush keeps the run of committed entries starting at the head.
  always_comb begin
    w_keep = '0;
    w_run  = 1'b1;
    for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
      if (w_run && (i < int'(r_count)) && w_committed_next[ptr_add(r_head, i)]) begin
        w_keep = w_keep + STBUF_CNT_WIDTH'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_items <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
        if (w_commit_hit[i]) r_items[i].committed <= 1'b1;
      end
      if (w_push) begin
        r_items[r_tail] <= '{rob_id:    exlsu_stbuf_rob_id,
                             addr:      exlsu_stbuf_write_addr,
                             size:      exlsu_stbuf_write_size,
                             data:      exlsu_stbuf_write_data,
                             committed: 1'b0};
      end
      if (w_flush) begin
        r_tail  <= ptr_add(r_head, int'(w_keep));
        r_count <= w_keep;
      end else begin
        if (w_push) r_tail <= ptr_add(r_tail, 1);
        if (w_pop)  r_head <= ptr_add(r_head, 1);
        r_count <= r_count + STBUF_CNT_WIDTH'(w_push) - STBUF_CNT_WIDTH'(w_pop);
      end
    end
  end

  assign bus.stbuf_bus_read_addr = issue_stbuf_read_addr;
  assign bus.stbuf_bus_read_size = issue_stbuf_read_size;
  assign bus.stbuf_bus_read_req  = issue_stbuf_rd;
  assign stbuf_exlsu_bus_ready   = bus.bus_stbuf_read_ack;
  assign stbuf_exlsu_bus_data    = bus.bus_stbuf_data;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic [STORE_BUFFER_SIZE-1:0][ADDR_WIDTH-1:0]     w_fwd_addr;
  logic [STORE_BUFFER_SIZE-1:0][SIZE_WIDTH-1:0]     w_fwd_size;
  logic [STORE_BUFFER_SIZE-1:0][REG_DATA_WIDTH-1:0] w_fwd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_read_addr <= '0;
    else if (issue_stbuf_rd) r_read_addr <= issue_stbuf_read_addr;
  end

  for (genvar g = 0; g < STORE_BUFFER_SIZE; g++) begin : g_fwd_fields
    assign w_fwd_addr[g] = r_items[g].addr;
    assign w_fwd_size[g] = r_items[g].size;
    assign w_fwd_data[g] = r_items[g].data;
  end

  store_buffer_forward u_forward (
    .i_entry_addr (w_fwd_addr),
    .i_entry_size (w_fwd_size),
    .i_entry_data (w_fwd_data),
    .i_head       (r_head),
    .i_count      (r_count),
    .i_read_addr  (r_read_addr),
    .i_bus_data   (bus.bus_stbuf_data),
    .o_feedback   (stbuf_exlsu_bus_data_feedback)
  );
`else
  assign stbuf_exlsu_bus_data_feedback = bus.bus_stbuf_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module      : tb_store_buffer
// Description : Scoreboard bench for store_buffer: directed stores, loads,
//               commits and flushes with queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;
  import store_buffer_pkg::*;

`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] BUSW = 32'hdeadbeef;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [SIZE_WIDTH-1:0]     rd_size;
  logic                      rd;
  logic [31:0]               bus_data_o, feedback;
  logic                      bus_ready;
  logic [ROB_ID_WIDTH-1:0]   rob_id;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [SIZE_WIDTH-1:0]     wr_size;
  logic [31:0]               wr_data;
  logic                      push;
  logic                      full, empty;
  commit_feedback_pack_t     pack;

  store_buffer_if bus_if();

  store_buffer dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .issue_stbuf_read_addr         (rd_addr),
    .issue_stbuf_read_size         (rd_size),
    .issue_stbuf_rd                (rd),
    .stbuf_exlsu_bus_data          (bus_data_o),
    .stbuf_exlsu_bus_data_feedback (feedback),
    .stbuf_exlsu_bus_ready         (bus_ready),
    .exlsu_stbuf_rob_id            (rob_id),
    .exlsu_stbuf_write_addr        (wr_addr),
    .exlsu_stbuf_write_size        (wr_size),
    .exlsu_stbuf_write_data        (wr_data),
    .exlsu_stbuf_push              (push),
    .stbuf_exlsu_full              (full),
    .stbuf_all_empty               (empty),
    .bus                           (bus_if),
    .commit_feedback_pack          (pack)
  );

  typedef struct { logic [31:0] data; logic [31:0] fb; } rd_exp_t;
  typedef struct { logic [ADDR_WIDTH-1:0] addr; logic [SIZE_WIDTH-1:0] size; logic [31:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT presents read data or a write beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_ready) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_read: got feedback 0x%0h, expected no read", feedback);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("read_bus_data", 64'(bus_data_o), 64'(e.data));
          check("read_feedback", 64'(feedback), 64'(e.fb));
        end
      end
      if (bus_if.stbuf_bus_write_req && bus_if.bus_stbuf_write_ack) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus_if.stbuf_bus_write_addr);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("write_addr", 64'(bus_if.stbuf_bus_write_addr), 64'(w.addr));
          check("write_size", 64'(bus_if.stbuf_bus_write_size), 64'(w.size));
          check("write_data", 64'(bus_if.stbuf_bus_data), 64'(w.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_store(input int rid, input logic [31:0] a, input int sz, input logic [31:0] d);
    rob_id = ROB_ID_WIDTH'(rid); wr_addr = a; wr_size = SIZE_WIDTH'(sz); wr_data = d; push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] fb_fwd);
    rd = 1'b1; rd_addr = a; rd_size = 3'd4;
    tick();
    rd = 1'b0;
    bus_if.bus_stbuf_data = BUSW; bus_if.bus_stbuf_read_ack = 1'b1;
    rd_q.push_back('{data: BUSW, fb: (FWD ? fb_fwd : BUSW)});
    tick();
    bus_if.bus_stbuf_read_ack = 1'b0;
  endtask

  task automatic flush_all();
    pack = '0; pack.enable = 1'b1; pack.flush = 1'b1;
    tick();
    pack = '0;
  endtask

  initial begin
    rd = 0; rd_addr = '0; rd_size = '0; rob_id = '0; wr_addr = '0; wr_size = '0; wr_data = '0;
    push = 0; pack = '0;
    bus_if.bus_stbuf_data = '0; bus_if.bus_stbuf_read_ack = 0; bus_if.bus_stbuf_write_ack = 0;
    do_reset();

    // Reset state and read pass-through
    @(negedge clk);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_full", 64'(full), 64'd0);
    check("reset_write_req", 64'(bus_if.stbuf_bus_write_req), 64'd0);
    @(posedge clk); #1;
    rd = 1'b1; rd_addr = 32'h1524abe0; rd_size = 3'd1;
    @(negedge clk);
    check("bus_read_addr", 64'(bus_if.stbuf_bus_read_addr), 64'h1524abe0);
    check("bus_read_size", 64'(bus_if.stbuf_bus_read_size), 64'd1);
    check("bus_read_req", 64'(bus_if.stbuf_bus_read_req), 64'd1);
    @(posedge clk); #1;
    rd = 1'b0;
    bus_if.bus_stbuf_data = BUSW; bus_if.bus_stbuf_read_ack = 1'b1;
    rd_q.push_back('{data: BUSW, fb: BUSW});
    tick();
    bus_if.bus_stbuf_read_ack = 1'b0;

    // Single-store forwarding windows
    push_store(1, 32'h0, 4, 32'haabbccdd); do_read(32'h0, 32'haabbccdd); flush_all();
    push_store(1, 32'h2, 4, 32'haabbccdd); do_read(32'h0, 32'hccddbeef); flush_all();
    push_store(1, 32'h0, 4, 32'haabbccdd); do_read(32'h2, 32'hdeadaabb); flush_all();
    push_store(1, 32'h0, 2, 32'haabbccdd); do_read(32'h0, 32'hdeadccdd); flush_all();

    // Multi-store merge across a misaligned window
    push_store(2, 32'h0, 2, 32'h0000ffee);
    push_store(3, 32'h3, 1, 32'h0000003f);
    push_store(4, 32'h4, 4, 32'hddccbbaa);
    do_read(32'h1, 32'haa3fbeff);
    flush_all();

    // Occupancy flags while pushing every cycle
    do_reset();
    push = 1'b1; wr_size = 3'd4;
    for (int i = 0; i <= STORE_BUFFER_SIZE; i++) begin
      rob_id = ROB_ID_WIDTH'(i); wr_addr = 32'(i); wr_data = 32'(i);
      @(negedge clk);
      check($sformatf("fill_empty_%0d", i), 64'(empty), 64'(i == 0));
      check($sformatf("fill_full_%0d", i), 64'(full), 64'(i == STORE_BUFFER_SIZE));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("full_after_drop", 64'(full), 64'd1);
    @(posedge clk); #1;
    push = 1'b0;
    flush_all();
    @(negedge clk);
    check("flush_full_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;

    // In-order drain of committed stores
    for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
      push_store(i, 32'(i), 4, 32'h1581abcf + 32'(i));
      wr_q.push_back('{addr: ADDR_WIDTH'(i), size: SIZE_WIDTH'(4), data: 32'h1581abcf + 32'(i)});
    end
    bus_if.bus_stbuf_write_ack = 1'b1;
    for (int s = 0; s < STORE_BUFFER_SIZE / COMMIT_WIDTH; s++) begin
      pack = '0; pack.enable = 1'b1;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        pack.committed_rob_id[j] = ROB_ID_WIDTH'(s * COMMIT_WIDTH + j);
        pack.committed_rob_id_valid[j] = 1'b1;
      end
      tick();
    end
    pack = '0;
    for (int t = 0; t < 40 && !empty; t++) tick();
    bus_if.bus_stbuf_write_ack = 1'b0;
    @(negedge clk);
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_all_written", 64'(wr_q.size()), 64'd0);
    @(posedge clk); #1;

    // Flush discards uncommitted, keeps same-cycle commits
    push_store(1, 32'h40, 4, 32'h11223344);
    rob_id = 7'd2; push = 1'b1;
    flush_all();
    push = 1'b0;
    @(negedge clk);
    check("flush_uncommitted_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;
    push_store(1, 32'h40, 4, 32'h11223344);
    pack = '0; pack.enable = 1'b1; pack.flush = 1'b1;
    pack.committed_rob_id[0] = 7'd1; pack.committed_rob_id_valid[0] = 1'b1;
    @(negedge clk);
    check("flush_commit_write_req", 64'(bus_if.stbuf_bus_write_req), 64'd0);
    @(posedge clk); #1;
    pack.committed_rob_id_valid[0] = 1'b0;
    @(negedge clk);
    check("flush_hold_write_req", 64'(bus_if.stbuf_bus_write_req), 64'd0);
    check("flush_kept_entry", 64'(empty), 64'd0);
    @(posedge clk); #1;
    pack = '0;
    wr_q.push_back('{addr: ADDR_WIDTH'(32'h40), size: SIZE_WIDTH'(4), data: 32'h11223344});
    bus_if.bus_stbuf_write_ack = 1'b1;
    @(negedge clk);
    check("post_flush_write_req", 64'(bus_if.stbuf_bus_write_req), 64'd1);
    @(posedge clk); #1;
    bus_if.bus_stbuf_write_ack = 1'b0;
    @(negedge clk);
    check("post_flush_empty", 64'(empty), 64'd1);
    check("reads_consumed", 64'(rd_q.size()), 64'd0);
    check("writes_consumed", 64'(wr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
